// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated 4:1 mux with one registered valid/ready output stage.
// Define RR_ARB_MUX_PKT_LOCK_EN to hold the grant across multi-beat packets.
module rr_arb_mux #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      req_valid,
    input  logic [4*DW-1:0] req_data,
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    input  logic [3:0]      req_last,
    output logic            out_last,
`endif
    output logic [3:0]      req_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_id,
    input  logic            out_ready
);

    logic [3:0]    mask_q, mask_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_id_q, out_id_d;

    logic [3:0] masked, cand, grant;
    logic [1:0] win_idx, sel_idx;
    logic       load, xfer, pkt_end;

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic       lock_q, lock_d;
    logic [1:0] lk_idx_q, lk_idx_d;
    logic       out_last_q, out_last_d;
`endif

    always_comb begin
        masked  = req_valid & mask_q;
        cand    = (masked != 4'b0000) ? masked : req_valid;
        win_idx = 2'd0;
        // scan downward so the lowest set index is the last one written
        for (int i = 3; i >= 0; i--) begin
            if (cand[i]) win_idx = 2'(i);
        end
        grant   = (cand != 4'b0000) ? (4'b0001 << win_idx) : 4'b0000;
        sel_idx = win_idx;
        pkt_end = 1'b1;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        if (lock_q) begin
            sel_idx = lk_idx_q;
            grant   = req_valid[lk_idx_q] ? (4'b0001 << lk_idx_q) : 4'b0000;
        end
        pkt_end = req_last[sel_idx];
`endif
        load      = !out_valid_q || out_ready;
        req_ready = (load && reset_n) ? grant : 4'b0000;
        xfer      = |(req_valid & req_ready);

        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lk_idx_d    = lk_idx_q;
        out_last_d  = out_last_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(sel_idx)*DW +: DW];
            out_id_d    = sel_idx;
            if (pkt_end) mask_d = 4'b1110 << sel_idx;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
            lock_d     = !req_last[sel_idx];
            lk_idx_d   = sel_idx;
            out_last_d = req_last[sel_idx];
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q      <= 4'b1111;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 2'd0;
        end else begin
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

`ifdef RR_ARB_MUX_PKT_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            lk_idx_q   <= 2'd0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lk_idx_q   <= lk_idx_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: rotation, back-pressure, wrap, reset, packet lock.
// Packet-lock vectors run only when RR_ARB_MUX_PKT_LOCK_EN is defined.
module tb_rr_arb_mux;

    localparam int DW = 8;

    logic          clk;
    logic          reset_n;
    logic [3:0]    req_valid;
    logic [7:0]    d [4];
    logic [4*DW-1:0] req_data;
    logic [3:0]    req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;
    logic          out_ready;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
    logic [3:0]    req_last;
    logic          out_last;
`endif

    int n_vec;
    int n_err;

    assign req_data = {d[3], d[2], d[1], d[0]};

    rr_arb_mux #(.DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        .req_last  (req_last),
        .out_last  (out_last),
`endif
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n   = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'b1111;
        d[0] = 8'hA0; d[1] = 8'hA1; d[2] = 8'hA2; d[3] = 8'hA3;
`ifdef RR_ARB_MUX_PKT_LOCK_EN
        req_last = 4'b1111;
`endif
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", 32'(out_data), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        reset_n = 1'b1;
        #1;

        // all four valid: rotation 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            chk("rot_ready", 32'(req_ready), 32'(4'b0001 << (k % 4)));
            cyc();
            chk("rot_valid", 32'(out_valid), 32'h1);
            chk("rot_id", 32'(out_id), 32'(k % 4));
            chk("rot_data", 32'(out_data), 32'(8'hA0 + k % 4));
        end

        // lone requester 2 is picked every cycle, masked or wrapped
        d[2] = 8'h55;
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("solo_ready", 32'(req_ready), 32'h4);
            cyc();
            chk("solo_id", 32'(out_id), 32'h2);
            chk("solo_data", 32'(out_data), 32'h55);
        end

        // back-pressure
        do_reset();
        req_valid = 4'b0011;
        out_ready = 1'b1;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'h1);
        cyc();
        chk("bp_first_id", 32'(out_id), 32'h0);
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_stall_ready", 32'(req_ready), 32'h0);
            cyc();
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_id", 32'(out_id), 32'h0);
            chk("bp_hold_data", 32'(out_data), 32'hA0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(req_ready), 32'h2);
        cyc();
        chk("bp_resume_id", 32'(out_id), 32'h1);
        chk("bp_resume_data", 32'(out_data), 32'hA1);
        req_valid = 4'b0000;
        cyc();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_id_hold", 32'(out_id), 32'h1);
        chk("drain_data_hold", 32'(out_data), 32'hA1);

        // grant 3 empties the mask, then wrap picks 1, mask becomes 1100
        req_valid = 4'b1000;
        cyc();
        chk("g3_id", 32'(out_id), 32'h3);
        req_valid = 4'b1010;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'h2);
        cyc();
        chk("wrap_id", 32'(out_id), 32'h1);
        req_valid = 4'b1011;
        #1;
        chk("mask1100_ready", 32'(req_ready), 32'h8);
        cyc();
        chk("mask1100_id", 32'(out_id), 32'h3);

        // reset while holding a word with mask 1000
        req_valid = 4'b0100;
        cyc();
        chk("pre_rst_id", 32'(out_id), 32'h2);
        out_ready = 1'b0;
        req_valid = 4'b1111;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        reset_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("postrst_ready", 32'(req_ready), 32'h1);
        cyc();
        chk("postrst_id", 32'(out_id), 32'h0);
        chk("postrst_data", 32'(out_data), 32'hA0);

`ifdef RR_ARB_MUX_PKT_LOCK_EN
        begin
            logic [1:0] exp_id [5];
            logic       exp_lst [5];
            exp_id  = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
            exp_lst = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            do_reset();
            chk("lock_rst_last", 32'(out_last), 32'h0);
            req_last  = 4'b1111;
            req_valid = 4'b0001;
            cyc();
            chk("lock_pre_id", 32'(out_id), 32'h0);
            req_valid = 4'b0111;
            req_last  = 4'b0101;
            for (int k = 0; k < 5; k++) begin
                if (k == 2) req_last = 4'b0111;
                cyc();
                chk("lock_id", 32'(out_id), 32'(exp_id[k]));
                chk("lock_last", 32'(out_last), 32'(exp_lst[k]));
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Four-requester arbitrated multiplexer that consumes round-robin grants and forwards the winning requester's data word to a single downstream valid/ready port through one output register stage.
- Sits directly downstream of the round-robin grant logic, replacing the bare one-hot grant with a complete data path and handshake.
- Gives each requester back-pressure, and advances fairness only on accepted transfers.

Parameters:
- DW, 8, data width per requester and of the output word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester valid; bit i belongs to requester i.
- req_data  input  4*DW  requester i data on bits [i*DW +: DW].
- req_ready  output  4  one-hot or zero; bit i high means requester i's word is taken this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  DW  registered winning data.
- out_id  output  2  registered index of the requester that supplied out_data.
- out_ready  input  1  downstream accepts when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - out_valid=0, out_data=0, out_id=0.
  - Mask register = 4'b1111, so requester 0 has highest priority first.
  - req_ready=0 while reset_n=0.
- Load enable: load = !out_valid || out_ready. The output slot is free or is being drained this cycle.
- Arbitration (combinational, evaluated every cycle):
  - masked = req_valid & mask.
  - Candidate set = masked if nonzero, else req_valid.
  - Winner = lowest set index of the candidate set; grant = one-hot of winner, or zero if req_valid=0.
- req_ready = load ? grant : 4'b0000. A requester transfer happens when req_valid[i] && req_ready[i].
- On a transfer from requester w:
  - out_data <= req_data[w].
  - out_id <= w.
  - out_valid <= 1.
  - mask <= w=0:1110, w=1:1100, w=2:1000, w=3:0000.
- No transfer and out_valid && out_ready: out_valid <= 0; out_data/out_id hold their last values.
- No transfer and no drain: all state holds; mask never changes without a transfer.
- Latency: a word accepted in cycle N appears on out_valid/out_data in cycle N+1.
- Throughput: one word per cycle when out_ready stays high (drain and load in the same cycle).
- Back-pressure: out_valid=1 && out_ready=0 gives req_ready=0. out_data, out_id and out_valid stay stable until accepted.
- Fairness: any requester holding req_valid high is served within 4 transfers.
- Boundary, mask 0000: all requests fall to the unmasked path, so priority wraps to requester 0.
- Boundary, all four valid: grants rotate 0,1,2,3,0 on consecutive transfers.
- Requester deasserting valid without a transfer: legal; no state is affected.
- Reset mid-operation: the pending output word is discarded and the mask returns to 1111 immediately.

Optional Feature:
- Macro RR_ARB_MUX_PKT_LOCK_EN.
- When defined:
  - Adds input req_last (4 bits) and output out_last (1 bit, registered with the data, reset 0).
  - A lock register, reset 0, plus a locked index register.
  - After a transfer from w with req_last[w]=0: lock=1 and the locked index = w.
  - While lock=1: grant = one-hot of the locked index if req_valid[locked] is high, else zero. Other requesters are blocked.
  - A transfer with req_last[w]=1 clears the lock.
  - The mask updates only on the transfer that carries last=1.
- When undefined:
  - No req_last or out_last ports; every word is treated as a complete packet.
  - Behaviour exactly as above.

Test Plan:
- Reset, then req_valid=4'b1111 with data 0xA0..0xA3 and out_ready=1 held -> out_id sequence 0,1,2,3,0 on consecutive cycles starting one cycle after the first accept; out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Only requester 2 valid (data 0x55), out_ready=1 -> req_ready=4'b0100 every cycle; out_data=0x55 and out_id=2 each cycle; mask stays 1000 then rotates back and still picks 2.
- out_ready=0 after the first word is loaded, req_valid=4'b0011 -> req_ready=0 while stalled; out_data, out_id and out_valid held; after out_ready=1, the next grant is requester 1, not 0.
- Grant to 3 (mask 0000), then req_valid=4'b1010 -> winner 1 (wrap path); mask becomes 1100.
- Assert reset_n=0 while out_valid=1 and the mask is 1000 -> out_valid=0 immediately; after release with req_valid=4'b1111, the first winner is 0.
- With RR_ARB_MUX_PKT_LOCK_EN: requester 1 sends 3 beats (last on beat 3) while 0 and 2 are valid -> out_id=1,1,1 with out_last only on beat 3, then 2, then 0.
